// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, FSM encoding and
// bit-period helpers derived from clock and baud rate.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic int calcDiv(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

    function automatic int calcDivWidth(input int clkFreq, input int baud);
        int d;
        d = clkFreq / baud;
        return (d < 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_param_if #(parameter int DATA_BITS = 8) ();

    logic [DATA_BITS-1:0] TxData;
    logic                 TxValid;
    logic                 TxReady;

    modport master (output TxData, output TxValid, input TxReady);
    modport slave  (input TxData, input TxValid, output TxReady);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and
// show-ahead read data; pushes into a full FIFO are refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WrEn,
    input  logic [WIDTH-1:0] WrData,
    input  logic             RdEn,
    output logic [WIDTH-1:0] RdData,
    output logic             Full,
    output logic             Empty,
    output logic [CW-1:0]    Count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    countNext;

    assign push   = WrEn && !Full;
    assign pop    = RdEn && !Empty;
    assign RdData = mem[rdPtr];

    always_comb begin
        countNext = Count;
        if (push && !pop)
            countNext = Count + 1'b1;
        else if (pop && !push)
            countNext = Count - 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
            Full  <= 1'b0;
            Empty <= 1'b1;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            Count <= countNext;
            Full  <= (countNext == CW'(DEPTH));
            Empty <= (countNext == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wrPtr] <= WrData;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, bit-period divider,
// LSB-first shifter with optional parity and 1 or 2 stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    uart_tx_param_if.slave                bus,
    output logic                          Tx,
    output logic                          Busy,
    output logic                          TxDone,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

    localparam int DIV = calcDiv(CLK_FREQ, BAUD);
    localparam int DW  = calcDivWidth(CLK_FREQ, BAUD);

    if (DIV < 2) begin : gBadDiv
        $error("uart_tx_param: CLK_FREQ/BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadParity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic                 full;
    logic                 empty;
    logic                 popEn;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .WrEn   (bus.TxValid),
        .WrData (bus.TxData),
        .RdEn   (popEn),
        .RdData (head),
        .Full   (full),
        .Empty  (empty),
        .Count  (FifoCount)
    );

    logic [2:0]           state;
    logic [DW-1:0]        divCnt;
    logic [3:0]           bitCnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parBit;
    logic                 divLast;
    logic                 lastStop;

    assign bus.TxReady = !full;
    assign divLast     = (divCnt == DW'(DIV - 1));
    assign lastStop    = (state == S_STOP) && divLast
                         && (bitCnt == 4'(STOP_BITS - 1));
    // The final stop cycle doubles as the pop slot so frames run back-to-back
    assign popEn       = !empty && ((state == S_IDLE) || lastStop);
    assign TxDone      = lastStop;
    assign Busy        = (state != S_IDLE) || (FifoCount != '0);

    always_comb begin
        Tx = 1'b1;
        case (state)
            S_START:  Tx = 1'b0;
            S_DATA:   Tx = shreg[0];
            S_PARITY: Tx = parBit;
            default:  Tx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= S_IDLE;
            divCnt <= '0;
            bitCnt <= '0;
            shreg  <= '0;
            parBit <= 1'b0;
        end else if (popEn) begin
            state  <= S_START;
            divCnt <= '0;
            bitCnt <= '0;
            shreg  <= head;
            parBit <= (^head) ^ (PARITY == int'(PARITY_ODD));
        end else if (state != S_IDLE) begin
            divCnt <= divLast ? '0 : divCnt + 1'b1;
            if (divLast) begin
                unique case (state)
                    S_START: begin
                        state  <= S_DATA;
                        bitCnt <= '0;
                    end
                    S_DATA: begin
                        shreg <= shreg >> 1;
                        if (bitCnt == 4'(DATA_BITS - 1)) begin
                            bitCnt <= '0;
                            state  <= (PARITY != int'(PARITY_NONE))
                                      ? S_PARITY : S_STOP;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        state  <= S_STOP;
                        bitCnt <= '0;
                    end
                    S_STOP: begin
                        if (bitCnt == 4'(STOP_BITS - 1))
                            state <= S_IDLE;
                        else
                            bitCnt <= bitCnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: 8N1, 8O1, 8E1 and 7E2 instances
// at DIV=10, with line monitors decoding every frame bit by bit.
module tb_uart_tx_param;

    localparam int CF    = 1000000;
    localparam int BR    = 100000;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    function automatic int dbOf(input int g);
        return (g == 3) ? 7 : 8;
    endfunction
    function automatic int parOf(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 2);
    endfunction
    function automatic int sbOf(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [8:0] txData [4];
    logic       txValid [4];
    logic       rdy [4];
    logic       tx [4];
    logic       busy [4];
    logic       done [4];
    logic [2:0] cnt [4];
    logic [9:0] expQ [4][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         doneCnt [4];
    int         lastDone [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gU
        localparam int DBG = dbOf(g);
        localparam int PG  = parOf(g);
        localparam int SG  = sbOf(g);
        localparam int NB  = 1 + DBG + ((PG != 0) ? 1 : 0) + SG;

        uart_tx_param_if #(.DATA_BITS(DBG)) bus ();

        assign bus.TxData  = txData[g][DBG-1:0];
        assign bus.TxValid = txValid[g];
        assign rdy[g]      = bus.TxReady;

        uart_tx_param #(
            .CLK_FREQ   (CF),
            .BAUD       (BR),
            .DATA_BITS  (DBG),
            .PARITY     (PG),
            .STOP_BITS  (SG),
            .FIFO_DEPTH (DEPTH)
        ) dut (
            .Clk       (clk),
            .Rst_n     (rstN),
            .bus       (bus.slave),
            .Tx        (tx[g]),
            .Busy      (busy[g]),
            .TxDone    (done[g]),
            .FifoCount (cnt[g])
        );

        always @(posedge clk) begin
            if (rstN && done[g]) begin
                doneCnt[g]  <= doneCnt[g] + 1;
                lastDone[g] <= cyc;
            end
        end

        always @(negedge rstN) expQ[g].delete();

        logic smp [NB*DIV];
        logic dn  [NB*DIV];

        initial begin : mon
            bit         abort;
            bit         tOk;
            logic [9:0] got;
            logic [9:0] e;
            forever begin
                @(negedge clk iff (rstN === 1'b1 && tx[g] === 1'b0));
                abort = 1'b0;
                for (int k = 0; k < NB * DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rstN) begin
                        abort = 1'b1;
                        break;
                    end
                    smp[k] = tx[g];
                    dn[k]  = done[g];
                end
                if (!abort) begin
                    tOk = 1'b1;
                    got = '0;
                    for (int b = 0; b < NB; b++)
                        for (int c = 0; c < DIV; c++) begin
                            if (smp[b*DIV+c] !== smp[b*DIV]) tOk = 1'b0;
                            if (dn[b*DIV+c] !== ((b == NB-1) && (c == DIV-1)))
                                tOk = 1'b0;
                        end
                    if (smp[0] !== 1'b0) tOk = 1'b0;
                    for (int s = 0; s < SG; s++)
                        if (smp[(NB-1-s)*DIV] !== 1'b1) tOk = 1'b0;
                    for (int i = 0; i < DBG; i++) got[i] = smp[(1+i)*DIV];
                    if (PG != 0) got[9] = smp[(1+DBG)*DIV];
                    checks++;
                    if (expQ[g].size() == 0) begin
                        errors++;
                        $display("FAIL frame_u%0d unexpected frame got %h", g, got);
                    end else begin
                        e = expQ[g].pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL frame_u%0d got %h want %h", g, got, e);
                        end
                    end
                    checks++;
                    if (!tOk) begin
                        errors++;
                        $display("FAIL timing_u%0d got bad bit timing want %0d bits x %0d cycles",
                                 g, NB, DIV);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic send(input int g, input logic [8:0] d, input logic p,
                        input bit hold);
        int n;
        n = 0;
        txData[g]  = d;
        txValid[g] = 1'b1;
        while (!rdy[g] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[g]) begin
            checks++;
            errors++;
            $display("FAIL send_u%0d got no TxReady want accept of %h", g, d);
        end else begin
            expQ[g].push_back({p, d});
        end
        @(negedge clk);
        if (!hold) txValid[g] = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1] && !busy[2] && !busy[3] &&
                expQ[0].size() == 0 && expQ[1].size() == 0 &&
                expQ[2].size() == 0 && expQ[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got busy after %0d cycles want idle", limit);
        end
    endtask

    initial begin
        int  v0;
        int  base;
        bit  seen;
        for (int g = 0; g < 4; g++) begin
            txValid[g]  = 1'b0;
            txData[g]   = '0;
            doneCnt[g]  = 0;
            lastDone[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            chk($sformatf("reset_u%0d", g),
                16'({tx[g], rdy[g], busy[g], done[g], cnt[g]}), 16'b1100000);
        rstN = 1'b1;
        @(negedge clk);

        send(0, 9'h55, 1'b0, 1'b0);
        chk("u0_after_push", 16'({tx[0], cnt[0]}), 16'({1'b1, 3'd1}));
        @(negedge clk);
        v0 = cyc;
        chk("u0_start_bit", 16'({tx[0], cnt[0], busy[0]}), 16'({1'b0, 3'd0, 1'b1}));

        send(1, 9'h55, 1'b1, 1'b0);
        send(2, 9'h55, 1'b0, 1'b0);
        send(3, 9'h41, 1'b0, 1'b0);
        send(1, 9'h07, 1'b0, 1'b0);
        send(2, 9'h07, 1'b1, 1'b0);
        send(3, 9'h7F, 1'b1, 1'b0);
        waitIdle(1000);
        chk("u0_frame_len", 16'(lastDone[0] - v0), 16'd99);

        base = doneCnt[0];
        send(0, 9'h01, 1'b0, 1'b1);
        v0 = cyc + 1;
        send(0, 9'h02, 1'b0, 1'b1);
        send(0, 9'h03, 1'b0, 1'b1);
        send(0, 9'h04, 1'b0, 1'b1);
        send(0, 9'h05, 1'b0, 1'b1);
        chk("u0_full", 16'({rdy[0], cnt[0]}), 16'({1'b0, 3'd4}));
        send(0, 9'h06, 1'b0, 1'b0);
        chk("u0_sixth_after_pop", 16'(doneCnt[0] - base), 16'd1);
        for (int i = 0; i < 1000 && doneCnt[0] < base + 6; i++) @(negedge clk);
        chk("u0_burst_dones", 16'(doneCnt[0] - base), 16'd6);
        chk("u0_burst_contiguous", 16'(lastDone[0] - v0), 16'd599);
        @(negedge clk);
        chk("u0_idle_after_burst", 16'({busy[0], cnt[0], tx[0]}), 16'({1'b0, 3'd0, 1'b1}));

        send(1, 9'h0F, 1'b1, 1'b0);
        send(1, 9'h3C, 1'b1, 1'b0);
        chk("u1_pushpop_first", 16'(cnt[1]), 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("u1_done_seen", 16'(seen), 16'd1);
        send(1, 9'hA3, 1'b1, 1'b0);
        chk("u1_pushpop_boundary", 16'({cnt[1], tx[1]}), 16'({3'd1, 1'b0}));
        waitIdle(1000);

        send(2, 9'h3C, 1'b0, 1'b0);
        repeat (35) @(negedge clk);
        base = doneCnt[2];
        rstN = 1'b0;
        #1;
        chk("u2_reset_immediate", 16'({tx[2], rdy[2], done[2]}), 16'b110);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("u2_after_release", 16'({cnt[2], busy[2], tx[2]}), 16'({3'd0, 1'b0, 1'b1}));
        repeat (150) @(negedge clk);
        chk("u2_no_done_after_abort", 16'(doneCnt[2] - base), 16'd0);
        for (int g = 0; g < 4; g++)
            chk($sformatf("drained_u%0d", g), 16'(expQ[g].size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
